// File: rtl/uart_rx.sv
// 8N1 asynchronous serial receiver: two-flop synchroniser, mid-bit sampling,
// LSB-first shift, stop-bit check and a valid/ack hand-off of each good byte.
module uart_rx #(
  parameter int CLK_FREQ = 48000000,
  parameter int BAUD     = 115200
) (
  input  logic       sourceClk,
  input  logic       reset,
  input  logic       rx_in,
  input  logic       rx_ack,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    RECOVER
  } state_t;

  state_t           state_q, state_d;
  logic             sync1_q, rxS_q;
  logic [CNT_W-1:0] baudCnt_q, baudCnt_d;
  logic [2:0]       bitIdx_q, bitIdx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       rxByte_q, rxByte_d;
  logic             rxValid_q, rxValid_d;
  logic             frameErr_q, frameErr_d;
  logic             overrun_q, overrun_d;

  always_ff @(posedge sourceClk) begin
    if (!reset) begin
      state_q    <= IDLE;
      sync1_q    <= 1'b1;
      rxS_q      <= 1'b1;
      baudCnt_q  <= '0;
      bitIdx_q   <= '0;
      shift_q    <= '0;
      rxByte_q   <= '0;
      rxValid_q  <= 1'b0;
      frameErr_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= rx_in;
      rxS_q      <= sync1_q;
      baudCnt_q  <= baudCnt_d;
      bitIdx_q   <= bitIdx_d;
      shift_q    <= shift_d;
      rxByte_q   <= rxByte_d;
      rxValid_q  <= rxValid_d;
      frameErr_q <= frameErr_d;
      overrun_q  <= overrun_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    baudCnt_d  = baudCnt_q;
    bitIdx_d   = bitIdx_q;
    shift_d    = shift_q;
    rxByte_d   = rxByte_q;
    rxValid_d  = rxValid_q;
    frameErr_d = 1'b0;
    overrun_d  = 1'b0;

    // An ack only matters while a byte is pending; a simultaneous good stop
    // bit below re-asserts valid with the fresh byte.
    if (rxValid_q && rx_ack) begin
      rxValid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (!rxS_q) begin
          baudCnt_d = '0;
          state_d   = START;
        end
      end
      START: begin
        if (baudCnt_q == HALF_LAST) begin
          baudCnt_d = '0;
          bitIdx_d  = '0;
          state_d   = rxS_q ? IDLE : DATA;
        end else begin
          baudCnt_d = baudCnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (baudCnt_q == BIT_LAST) begin
          baudCnt_d = '0;
          shift_d   = {rxS_q, shift_q[7:1]};
          if (bitIdx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bitIdx_d = bitIdx_q + 3'd1;
          end
        end else begin
          baudCnt_d = baudCnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (baudCnt_q == BIT_LAST) begin
          baudCnt_d = '0;
          if (rxS_q) begin
            state_d = IDLE;
            if (rxValid_q && !rx_ack) begin
              overrun_d = 1'b1;
            end else begin
              rxByte_d  = shift_q;
              rxValid_d = 1'b1;
            end
          end else begin
            frameErr_d = 1'b1;
            state_d    = RECOVER;
          end
        end else begin
          baudCnt_d = baudCnt_q + CNT_W'(1);
        end
      end
      RECOVER: begin
        if (rxS_q) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rx_byte   = rxByte_q;
  assign rx_valid  = rxValid_q;
  assign rx_busy   = (state_q != IDLE);
  assign frame_err = frameErr_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 16 clocks per bit: directed frames push
// expected bytes, a negedge monitor pops them whenever a new byte is presented.
module tb_uart_rx;

  logic       sourceClk = 1'b0;
  logic       reset;
  logic       rx_in;
  logic       rx_ack;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_err;
  logic       overrun;

  int errors = 0;
  int checks = 0;
  int cycleCount = 0;
  int frameErrCount = 0;
  int overrunCount = 0;
  int eventCount = 0;
  int lastEventCycle = 0;
  int startCycle = 0;
  logic       autoAck = 1'b0;
  logic       prevValid = 1'b0;
  logic [7:0] prevByte = 8'h00;
  logic [7:0] expByte;
  logic [7:0] expQ[$];

  uart_rx #(
    .CLK_FREQ(1600),
    .BAUD    (100)
  ) dut (
    .sourceClk(sourceClk),
    .reset    (reset),
    .rx_in    (rx_in),
    .rx_ack   (rx_ack),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .rx_busy  (rx_busy),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 sourceClk = ~sourceClk;

  always @(posedge sourceClk) cycleCount = cycleCount + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // A new byte is presented when valid rises, or when the byte changes under
  // a held valid (ack coinciding with a good stop bit).
  always @(negedge sourceClk) begin
    if (frame_err) frameErrCount++;
    if (overrun) overrunCount++;
    if (rx_valid && (!prevValid || rx_byte != prevByte)) begin
      eventCount++;
      lastEventCycle = cycleCount;
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected byte: got 0x%0h, expected none", rx_byte);
      end else begin
        expByte = expQ.pop_front();
        checkOutput("received byte", int'(rx_byte), int'(expByte));
      end
    end
    prevValid = rx_valid;
    prevByte  = rx_byte;
  end

  task automatic tick();
    @(negedge sourceClk);
    #1;
    rx_ack = autoAck && rx_valid && !rx_ack;
  endtask

  // Drives one 10-bit frame; cpb100 is the bit period in hundredths of a
  // clock so baud skew can be modelled. ackCycle forces rx_ack on one cycle.
  task automatic applyStimulus(input logic [7:0] data, input logic stopBit,
                               input int cpb100, input int ackCycle);
    int total;
    int idx;
    total = (10 * cpb100 + 99) / 100;
    for (int c = 0; c < total; c++) begin
      tick();
      if (c == 0) startCycle = cycleCount;
      idx = (c * 100) / cpb100;
      if (idx == 0)      rx_in = 1'b0;
      else if (idx <= 8) rx_in = data[idx-1];
      else               rx_in = stopBit;
      if (c == ackCycle) rx_ack = 1'b1;
    end
  endtask

  int ev0, fe0, ov0, lat;

  initial begin
    reset  = 1'b0;
    rx_in  = 1'b1;
    rx_ack = 1'b0;
    repeat (3) tick();
    checkOutput("reset rx_valid", int'(rx_valid), 0);
    checkOutput("reset rx_byte", int'(rx_byte), 0);
    checkOutput("reset rx_busy", int'(rx_busy), 0);
    checkOutput("reset frame_err", int'(frame_err), 0);
    checkOutput("reset overrun", int'(overrun), 0);
    reset = 1'b1;
    repeat (3) tick();

    // Single byte, latency and manual ack
    ev0 = eventCount;
    expQ.push_back(8'h4F);
    applyStimulus(8'h4F, 1'b1, 1600, -1);
    repeat (4) tick();
    checkOutput("single byte event count", eventCount - ev0, 1);
    lat = lastEventCycle - startCycle;
    checks++;
    if (lat < 154 || lat > 156) begin
      errors++;
      $display("[TB] FAIL latency: got %0d cycles, expected 155 +/-1", lat);
    end
    checkOutput("held rx_valid", int'(rx_valid), 1);
    checkOutput("held rx_byte", int'(rx_byte), 8'h4F);
    rx_ack = 1'b1;
    tick();
    checkOutput("valid cleared by ack", int'(rx_valid), 0);

    // Back-to-back frames with prompt acks
    autoAck = 1'b1;
    ev0 = eventCount; fe0 = frameErrCount; ov0 = overrunCount;
    expQ.push_back(8'h4F); applyStimulus(8'h4F, 1'b1, 1600, -1);
    expQ.push_back(8'h6B); applyStimulus(8'h6B, 1'b1, 1600, -1);
    expQ.push_back(8'h0D); applyStimulus(8'h0D, 1'b1, 1600, -1);
    expQ.push_back(8'h0A); applyStimulus(8'h0A, 1'b1, 1600, -1);
    repeat (5) tick();
    checkOutput("back-to-back events", eventCount - ev0, 4);
    checkOutput("back-to-back frame_err", frameErrCount - fe0, 0);
    checkOutput("back-to-back overrun", overrunCount - ov0, 0);
    checkOutput("back-to-back queue drained", expQ.size(), 0);

    // Glitch on the start bit
    ev0 = eventCount; fe0 = frameErrCount;
    tick();
    rx_in = 1'b0;
    repeat (3) tick();
    checkOutput("glitch busy during start", int'(rx_busy), 1);
    tick();
    rx_in = 1'b1;
    repeat (20) tick();
    checkOutput("glitch busy after", int'(rx_busy), 0);
    checkOutput("glitch rx_valid", int'(rx_valid), 0);
    checkOutput("glitch frame_err", frameErrCount - fe0, 0);
    checkOutput("glitch events", eventCount - ev0, 0);

    // Framing error, line break, recovery
    ev0 = eventCount; fe0 = frameErrCount;
    applyStimulus(8'h55, 1'b0, 1600, -1);
    checkOutput("frame_err pulses", frameErrCount - fe0, 1);
    checkOutput("frame_err rx_valid", int'(rx_valid), 0);
    repeat (50) tick();
    checkOutput("break holds busy", int'(rx_busy), 1);
    checkOutput("break frame_err pulses", frameErrCount - fe0, 1);
    checkOutput("break events", eventCount - ev0, 0);
    rx_in = 1'b1;
    repeat (5) tick();
    checkOutput("recover to idle", int'(rx_busy), 0);
    expQ.push_back(8'hA5);
    applyStimulus(8'hA5, 1'b1, 1600, -1);
    repeat (5) tick();
    checkOutput("after break queue drained", expQ.size(), 0);

    // Overrun, then ack coinciding with the stop-sample edge
    autoAck = 1'b0;
    ov0 = overrunCount;
    expQ.push_back(8'h11);
    applyStimulus(8'h11, 1'b1, 1600, -1);
    repeat (3) tick();
    applyStimulus(8'h22, 1'b1, 1600, -1);
    repeat (3) tick();
    checkOutput("overrun pulses", overrunCount - ov0, 1);
    checkOutput("overrun keeps byte", int'(rx_byte), 8'h11);
    checkOutput("overrun keeps valid", int'(rx_valid), 1);
    expQ.push_back(8'h22);
    applyStimulus(8'h22, 1'b1, 1600, 154);
    repeat (3) tick();
    checkOutput("ack+stop byte", int'(rx_byte), 8'h22);
    checkOutput("ack+stop valid", int'(rx_valid), 1);
    checkOutput("ack+stop no overrun", overrunCount - ov0, 1);

    // Reset during data bit 3 of 0xFF
    fe0 = frameErrCount; ov0 = overrunCount;
    for (int c = 0; c < 70; c++) begin
      tick();
      rx_in = (c < 16) ? 1'b0 : 1'b1;
    end
    tick();
    reset = 1'b0;
    tick();
    checkOutput("mid-frame reset rx_byte", int'(rx_byte), 0);
    checkOutput("mid-frame reset rx_valid", int'(rx_valid), 0);
    checkOutput("mid-frame reset rx_busy", int'(rx_busy), 0);
    checkOutput("mid-frame reset frame_err", int'(frame_err), 0);
    checkOutput("mid-frame reset overrun", int'(overrun), 0);
    reset = 1'b1;
    repeat (5) tick();
    checkOutput("reset no frame_err", frameErrCount - fe0, 0);
    checkOutput("reset no overrun", overrunCount - ov0, 0);

    // Nominal and +/-3% skewed frames
    autoAck = 1'b1;
    ev0 = eventCount;
    expQ.push_back(8'h3C); applyStimulus(8'h3C, 1'b1, 1600, -1);
    repeat (5) tick();
    expQ.push_back(8'h3C); applyStimulus(8'h3C, 1'b1, 1648, -1);
    repeat (5) tick();
    expQ.push_back(8'h3C); applyStimulus(8'h3C, 1'b1, 1552, -1);
    repeat (5) tick();
    checkOutput("skew events", eventCount - ev0, 3);
    checkOutput("final queue drained", expQ.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Receive half of the Schoko UART: an 8N1 asynchronous serial receiver on the 48 MHz system clock. It synchronises the client's Tx line, which arrives on PMOD_B4, and validates the start bit at mid-bit. It samples eight data bits LSB-first, checks the stop bit, and presents each byte through a valid/ack handshake to the top-level state machine. Framing and overrun errors are reported as one-cycle pulses.

## Interface
Parameters:
- CLK_FREQ, 48000000, system clock in Hz
- BAUD, 115200, line rate in bits/s
- CLKS_PER_BIT (localparam), CLK_FREQ/BAUD with integer truncation; 416 at the default values
- HALF_BIT (localparam), CLKS_PER_BIT/2; 208 at the default values

Ports:
- sourceClk  in  1  system clock, rising-edge
- reset  in  1  synchronous, active-low reset
- rx_in  in  1  raw serial line, idle high, asynchronous to sourceClk
- rx_ack  in  1  consumer accepts rx_byte; sampled on the rising edge
- rx_byte  out  8  last good received byte
- rx_valid  out  1  rx_byte holds an unconsumed byte
- rx_busy  out  1  a frame is in progress (state is not Idle)
- frame_err  out  1  one-cycle pulse: stop bit sampled low
- overrun  out  1  one-cycle pulse: a good frame completed while rx_valid=1 and rx_ack=0

## Operation
- Synchroniser: rx_in passes through two flops, sync1 then rx_s. Both flops reset to 1. All logic uses only rx_s.
- Bit counter: 3-bit index. Baud counter: wide enough for CLKS_PER_BIT-1 (9 bits at the defaults).
- State machine:
  - Idle: when rx_s=0, clear the baud counter and go to Start.
  - Start: count to HALF_BIT-1. At that count, if rx_s=0, clear the counter and go to Data. If rx_s=1 (glitch), return to Idle with no error.
  - Data: count to CLKS_PER_BIT-1. At that count, shift rx_s into shift_reg[7] (right shift, LSB first). After bit index 7, go to Stop; otherwise increment the index.
  - Stop: count to CLKS_PER_BIT-1. At that count:
    - rx_s=1: load rx_byte from shift_reg, set rx_valid=1, go to Idle.
    - rx_s=0: pulse frame_err, leave rx_byte and rx_valid unchanged, go to Recover.
  - Recover: stay until rx_s=1, then go to Idle. This prevents a line break from retriggering.
- Handshake:
  - rx_valid stays high until a rising edge with rx_ack=1; it clears on that edge.
  - rx_ack while rx_valid=0 is ignored.
- Overrun (a good stop bit while rx_valid=1 and rx_ack=0 on the same edge):
  - overrun pulses for one cycle.
  - The new byte is discarded; rx_byte keeps the old byte and rx_valid stays 1.
- Simultaneous good stop bit and rx_ack=1 on the same edge: the new byte loads, rx_valid stays 1, no overrun.
- Reset: reset=0 at a rising edge forces state Idle, rx_byte=0x00, rx_valid=0, rx_busy=0, frame_err=0, overrun=0, counters=0, shift_reg=0, and both synchroniser flops to 1. This applies at any point, including mid-frame. The partially received byte is lost and no pulse is emitted.

## Timing
- Let t0 be the edge on which Idle sees rx_s=0. rx_s lags rx_in by 2 cycles.
- Start-bit check: t0+HALF_BIT.
- Data bit n (n=0..7) sampled at t0+HALF_BIT+(n+1)*CLKS_PER_BIT.
- Stop bit sampled at t0+HALF_BIT+9*CLKS_PER_BIT.
- rx_valid, frame_err and overrun change on the stop-sample edge itself, i.e. they are visible the cycle after that edge.
- Latency from the start-bit falling edge on rx_in to rx_valid high: 2 + HALF_BIT + 9*CLKS_PER_BIT + 1 cycles, with ±1 cycle of edge-alignment uncertainty.
- The receiver is ready for the next start bit on the cycle after returning to Idle. Back-to-back frames with a single stop bit are supported.
- Baud error from truncation is 0.16% at the defaults; a transmitter off by up to ±3% must still be received.
- rx_busy is combinational from state: 0 in Idle, 1 in Start/Data/Stop/Recover.

## Test plan
Benches use CLK_FREQ=1600 and BAUD=100, giving CLKS_PER_BIT=16 and HALF_BIT=8.
- Single byte 0x4F, rx_ack held 0 -> rx_valid rises at the computed latency, rx_byte=0x4F. Pulsing rx_ack for one cycle clears rx_valid on the next edge.
- Back-to-back 0x4F, 0x6B, 0x0D, 0x0A, each acked within 2 cycles of rx_valid -> four valid events in order, no frame_err, no overrun.
- Glitch: rx_in low for 4 cycles, then high -> state returns to Idle, rx_valid=0, frame_err=0, rx_busy back to 0.
- Stop bit forced low on 0x55 -> exactly one frame_err pulse, rx_valid stays 0. Hold rx_in low for 50 cycles -> the block stays in Recover with no second frame started. Release high, then send 0xA5 -> 0xA5 received correctly.
- Overrun: send 0x11 with no ack, then 0x22 -> overrun pulses once, rx_byte=0x11. Repeat with rx_ack=1 on the stop-sample edge of 0x22 -> rx_byte=0x22, rx_valid=1, no overrun.
- Reset asserted during data bit 3 of 0xFF -> all outputs at reset values next cycle. After release, 0x3C is received correctly; ±3% baud skew on the stimulus still yields 0x3C.
